// File: rtl/status_flags.sv
// rtl/status_flags.sv - 6502/65Org16 processor status register with IRQ/NMI input conditioning
module status_flags #(
    parameter int dw           = 16,
    parameter int CLR_D_ON_INT = 0,
    parameter int BCD_EN       = 1
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          RDY,
    input  logic          alu_CO,
    input  logic          alu_V,
    input  logic          alu_Z,
    input  logic          alu_N,
    input  logic          upd_nz,
    input  logic          upd_c,
    input  logic          upd_v,
    input  logic          bit_load,
    input  logic          plp,
    input  logic          flag_wr,
    input  logic [1:0]    flag_sel,
    input  logic          flag_val,
    input  logic [dw-1:0] DB,
    input  logic          push_b,
    input  logic          int_ack,
    input  logic          irq_n,
    input  logic          nmi_n,
    output logic [7:0]    P,
    output logic          CI,
    output logic          BCD,
    output logic [dw-1:0] PUSH,
    output logic          IRQ_req,
    output logic          NMI_req
);

    logic n_f, v_f, d_f, i_f, z_f, c_f;
    logic n_nx, v_nx, d_nx, i_nx, z_nx, c_nx;
    logic irq_s1, irq_s2;
    logic nmi_s1, nmi_s2, nmi_s3;
    logic nmi_pending;
    logic nmi_fall;
    logic unused_db;

    // DB bits outside [7:0] and the top two are don't-care for this block
    assign unused_db = &{1'b0, DB};

    // Each flag picks its highest-priority source; unrelated sources stay independent
    always_comb begin
        c_nx = c_f;
        z_nx = z_f;
        i_nx = i_f;
        d_nx = d_f;
        v_nx = v_f;
        n_nx = n_f;

        if (plp)                                  c_nx = DB[0];
        else if (flag_wr && flag_sel == 2'b00)    c_nx = flag_val;
        else if (upd_c)                           c_nx = alu_CO;

        if (plp)                                  z_nx = DB[1];
        else if (bit_load || upd_nz)              z_nx = alu_Z;

        if (plp)                                  i_nx = DB[2];
        else if (int_ack)                         i_nx = 1'b1;
        else if (flag_wr && flag_sel == 2'b01)    i_nx = flag_val;

        if (plp)                                  d_nx = DB[3];
        else if (int_ack && CLR_D_ON_INT != 0)    d_nx = 1'b0;
        else if (flag_wr && flag_sel == 2'b10)    d_nx = flag_val;

        if (plp)                                  v_nx = DB[6];
        else if (flag_wr && flag_sel == 2'b11)    v_nx = flag_val;
        else if (bit_load)                        v_nx = DB[dw-2];
        else if (upd_v)                           v_nx = alu_V;

        if (plp)                                  n_nx = DB[7];
        else if (bit_load)                        n_nx = DB[dw-1];
        else if (upd_nz)                          n_nx = alu_N;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            n_f <= 1'b0;
            v_f <= 1'b0;
            d_f <= 1'b0;
            i_f <= 1'b1;
            z_f <= 1'b0;
            c_f <= 1'b0;
        end else if (RDY) begin
            n_f <= n_nx;
            v_f <= v_nx;
            d_f <= d_nx;
            i_f <= i_nx;
            z_f <= z_nx;
            c_f <= c_nx;
        end
    end

    // Interrupt synchronisers run every cycle so RDY stalls cannot lose an NMI edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            irq_s1 <= 1'b1;
            irq_s2 <= 1'b1;
            nmi_s1 <= 1'b1;
            nmi_s2 <= 1'b1;
            nmi_s3 <= 1'b1;
        end else begin
            irq_s1 <= irq_n;
            irq_s2 <= irq_s1;
            nmi_s1 <= nmi_n;
            nmi_s2 <= nmi_s1;
            nmi_s3 <= nmi_s2;
        end
    end

    assign nmi_fall = ~nmi_s2 & nmi_s3;

    // A fresh edge outranks the acknowledge clear so back-to-back NMIs are not dropped
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            nmi_pending <= 1'b0;
        else if (nmi_fall)
            nmi_pending <= 1'b1;
        else if (int_ack && RDY && nmi_pending)
            nmi_pending <= 1'b0;
    end

    assign P       = {n_f, v_f, 1'b1, 1'b1, d_f, i_f, z_f, c_f};
    assign CI      = c_f;
    assign BCD     = d_f & (BCD_EN != 0);
    assign IRQ_req = ~irq_s2 & ~i_f;
    assign NMI_req = nmi_pending;

    always_comb begin
        PUSH      = '0;
        PUSH[7:0] = {n_f, v_f, 1'b1, push_b, d_f, i_f, z_f, c_f};
    end

endmodule
